// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for an active-low common-anode seven-segment display.
// Scans one digit per slot, snapshots inputs once per frame, blanks ghosting and leading zeros.
module sseg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_en;
    logic                  snap_lz;

    logic [N_DIGITS-1:0] dark;
    logic                hi_zero;
    logic [3:0]          cur_nib;
    logic                cur_dark;
    logic                cur_dp;
    logic [N_DIGITS-1:0] an_sel;
    logic                blank_now;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Leading-zero run is tracked from the most significant digit downward.
    always_comb begin
        hi_zero = 1'b1;
        dark    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (snap_digits[4*i +: 4] == 4'd0) && !snap_dp[i];
            dark[i] = !snap_en[i] || (snap_lz && (i != 0) && hi_zero);
        end
    end

    always_comb begin
        cur_nib  = 4'd0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        an_sel   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = snap_digits[4*i +: 4];
                cur_dark  = dark[i];
                cur_dp    = snap_dp[i];
                an_sel[i] = 1'b0;
            end
        end
        blank_now = (int'(cnt) < BLANK_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
            snap_digits <= digits;
            snap_dp     <= dp;
            snap_en     <= digit_en;
            snap_lz     <= blank_lz;
        end else begin
            frame_start <= 1'b0;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx         <= '0;
                    frame_start <= 1'b1;
                    snap_digits <= digits;
                    snap_dp     <= dp;
                    snap_en     <= digit_en;
                    snap_lz     <= blank_lz;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (blank_now || cur_dark) begin
                an   <= '1;
                seg  <= 7'h7F;
                dp_n <= 1'b1;
            end else begin
                an   <= an_sel;
                seg  <= decode(cur_nib);
                dp_n <= !cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with N_DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    sseg_scan_driver #(.N_DIGITS(8), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .digits(digits), .dp(dp), .digit_en(digit_en),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic        lz;
        logic [7:0]  shown;
        logic [55:0] segs;
    } vec_t;

    vec_t vecs[8];

    localparam logic [15:0] DARK = {8'hFF, 7'h7F, 1'b1};

    function automatic logic [55:0] pk(input logic [6:0] s0, s1, s2, s3, s4, s5, s6, s7);
        pk = {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        outs = {an, seg, dp_n};
    endfunction

    task automatic wait_fs();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 40);
        chk("frame_start wait", {15'd0, frame_start}, 16'd1);
    endtask

    // After reset drops: one dark cycle, then slot 0 of the reset-time snapshot;
    // frame_start must first appear 32 cycles after release.
    task automatic post_release(input logic [6:0] s0, input logic [31:0] new_digits);
        int fs_at = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 1) begin
                digits = new_digits;
                chk("release dark", outs(), DARK);
            end else if (n <= 4) begin
                chk("release slot0", outs(), {8'hFE, s0, 1'b1});
            end
            if (frame_start && fs_at < 0) fs_at = n;
        end
        chk("first frame_start", 16'(fs_at), 16'd32);
    endtask

    task automatic apply(input vec_t v, input int vi);
        logic [15:0] exp;
        digits   = v.digits;
        dp       = v.dp;
        digit_en = v.en;
        blank_lz = v.lz;
        wait_fs();
        for (int s = 0; s < 8; s++) begin
            step();
            chk($sformatf("v%0d slot%0d blank", vi, s), outs(), DARK);
            exp = v.shown[s] ? {~(8'b1 << s), v.segs[7*s +: 7], ~v.dp[s]} : DARK;
            for (int c = 1; c < 4; c++) begin
                step();
                chk($sformatf("v%0d slot%0d c%0d", vi, s, c), outs(), exp);
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0123, 8'h00, 8'hFF, 1'b1, 8'h07, pk(7'h30, 7'h24, 7'h79, 0, 0, 0, 0, 0)};
        vecs[1] = '{32'h0000_0123, 8'h00, 8'hFF, 1'b0, 8'hFF,
                    pk(7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[2] = '{32'h0000_0123, 8'h20, 8'hFF, 1'b1, 8'h3F,
                    pk(7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 0, 0)};
        vecs[3] = '{32'h0000_000C, 8'h00, 8'hFE, 1'b0, 8'hFE,
                    pk(0, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[4] = '{32'h0000_000C, 8'h00, 8'hFF, 1'b1, 8'h01, pk(7'h3F, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{32'h9876_5432, 8'h00, 8'hFF, 1'b1, 8'hFF,
                    pk(7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10)};
        vecs[6] = '{32'h0010_0001, 8'h00, 8'hEF, 1'b1, 8'h2F,
                    pk(7'h79, 7'h40, 7'h40, 7'h40, 0, 7'h79, 0, 0)};
        vecs[7] = '{32'h0000_AB00, 8'h00, 8'hFF, 1'b1, 8'h0F,
                    pk(7'h40, 7'h40, 7'h3F, 7'h3F, 0, 0, 0, 0)};

        // Power-up reset with digit 8 captured into the snapshot.
        reset = 1'b1; digits = 32'h0000_0008; dp = 8'h00; digit_en = 8'hFF; blank_lz = 1'b1;
        step(); step(); step();
        chk("reset outputs", outs(), DARK);
        chk("reset frame_start", {15'd0, frame_start}, 16'd0);
        reset = 1'b0;
        post_release(7'h00, 32'h0000_0003);

        for (int i = 0; i < 8; i++) apply(vecs[i], i);

        // Mid-frame input change must wait for the next frame.
        digits = 32'h0000_0001; dp = 8'h00; digit_en = 8'hFF; blank_lz = 1'b1;
        wait_fs();
        for (int n = 1; n <= 32; n++) begin
            step();
            if (n == 4) chk("midframe old slot0", outs(), {8'hFE, 7'h79, 1'b1});
            if (n == 14) digits = 32'h0000_0009;
            if (n == 20) chk("midframe held", outs(), DARK);
        end
        chk("midframe frame_start", {15'd0, frame_start}, 16'd1);
        step();
        step();
        chk("midframe new slot0", outs(), {8'hFE, 7'h10, 1'b1});

        // Reset during slot 5 aborts the scan and snapshots the reset-time inputs.
        digits = 32'h0000_0123; blank_lz = 1'b0;
        wait_fs();
        for (int n = 1; n <= 22; n++) step();
        chk("pre-reset slot5", outs(), {8'hDF, 7'h40, 1'b1});
        digits = 32'h0000_0005; blank_lz = 1'b1; reset = 1'b1;
        step();
        chk("midscan reset dark", outs(), DARK);
        chk("midscan reset fs", {15'd0, frame_start}, 16'd0);
        reset = 1'b0;
        post_release(7'h12, 32'h0000_0007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
